// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width,
// and the bit-counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold WIDTH itself so the last RUN increment never wraps.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fullAdder.sv
// Single-bit full-adder cell used by the serial datapath.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per RUN
// cycle, LSB first; the registered result appears for one DONE cycle.
//
// Handshake: an operation is accepted on a rising edge where start=1 and the
// block is IDLE (and not on the first edge after reset release); done is a
// one-cycle Moore pulse, busy covers RUN and DONE, and start is ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int               CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q;
  logic             fa_s, fa_c;

  fullAdder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // armed_q blocks acceptance on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + ONE;
        // sum/cout update only on the final bit so partial results never show.
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN) || (state_q == DONE);
    done      = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to add a, b, cin; sampled on clk rising edge.
REQ-005 Port: a  input  WIDTH  addend A, sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  addend B, sampled only on an accepted start.
REQ-007 Port: cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 Port: sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL load a, b into operand shift registers, cin into carry flop, clear bit counter, go RUN.
REQ-014 RUN: each edge SHALL add operand LSBs plus carry flop in one full-adder cell, shift the sum bit into the result register MSB, shift operands right, update carry flop with cell carry-out, increment counter.
REQ-015 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge state SHALL go DONE, sum SHALL take the full result, and cout SHALL take the final carry.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 done SHALL be high only in DONE (Moore); busy SHALL be high in RUN and DONE.
REQ-018 Latency: start accepted at edge E0 -> done high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-019 start SHALL be ignored in RUN and DONE; a, b, cin changes during RUN SHALL not affect the result.
REQ-020 start high in the first IDLE cycle after DONE SHALL be accepted (back-to-back throughput WIDTH+2 cycles per operation).
REQ-021 sum and cout SHALL hold their last value from DONE until the next completion; intermediate RUN values SHALL not appear on sum/cout.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap during RUN.

Reset
REQ-023 rst high SHALL immediately force state IDLE, busy 0, done 0, sum 0, cout 0, carry flop 0, counter 0, operand registers 0.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deassertion SHALL run normally.
REQ-025 start coincident with the rst-release edge SHALL be ignored.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH SHALL live in the shared team definitions package/include.
REQ-027 The per-bit add SHALL instantiate the existing fullAdder cell as the single sub-module; no behavioural "+" on operands.
REQ-028 All flops SHALL be in one clocked process with asynchronous rst; next-state and output decode SHALL be separate combinational logic.

Verification
REQ-029 WIDTH=8, a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0, done exactly 9 cycles after start edge, busy 9 cycles.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 a=8'hA5, b=8'h3C, cin=0, then start pulsed and a/b changed at RUN cycles 2 and 5 -> single done, sum=8'hE1, cout=0.
REQ-032 rst asserted at RUN cycle 4 -> busy/done/sum/cout 0 at once, no done; next start a=8'h10, b=8'h20 -> sum=8'h30.
REQ-033 start held high continuously -> done pulses every 10 cycles, each result correct.
REQ-034 WIDTH=3 exhaustive: all 128 (a,b,cin) combinations -> {cout,sum} equals a+b+cin.
